// File: rtl/tlul_gpio_device.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tlul_gpio_device (with tlul_pkg)                           |
// | Description : TL-UL responder exposing a GPIO register file: DATA_IN,    |
// |               DIR, OUT_SET, DATA_OUT, OUT_CLR. One outstanding request,  |
// |               registered D response, 2-flop input synchronizer.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package tlul_pkg;
    localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0] GET              = 3'h4;
    localparam logic [2:0] ACCESS_ACK       = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;
    localparam logic [7:0] TL_D_USER_DEFAULT = 8'h00;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [7:0]  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [7:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_gpio_device #(
    parameter int unsigned NUM_GPIO  = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3001_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tlul_pkg::tl_h2d_t   tl_i,
    output tlul_pkg::tl_d2h_t   tl_o,
    input  logic [NUM_GPIO-1:0] gpio_i,
    output logic [NUM_GPIO-1:0] gpio_o,
    output logic [NUM_GPIO-1:0] gpio_oe_o
);
    import tlul_pkg::*;

    localparam logic [7:0] c_off_data_in  = 8'h00;
    localparam logic [7:0] c_off_dir      = 8'h04;
    localparam logic [7:0] c_off_out_set  = 8'h10;
    localparam logic [7:0] c_off_data_out = 8'h14;
    localparam logic [7:0] c_off_out_clr  = 8'h18;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [NUM_GPIO-1:0] r_sync1;
    logic [NUM_GPIO-1:0] r_sync2;
    logic [NUM_GPIO-1:0] r_dir;
    logic [NUM_GPIO-1:0] r_dout;

    logic [2:0]  r_d_opcode;
    logic [1:0]  r_d_size;
    logic [7:0]  r_d_source;
    logic [31:0] r_d_data;
    logic        r_d_error;

    logic        w_accept;
    logic        w_in_window;
    logic        w_mapped;
    logic        w_is_get;
    logic        w_is_put;
    logic        w_err;
    logic        w_wr_en;
    logic [7:0]  w_off;
    logic [31:0] w_bmask;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [31:0] w_dir_ext;
    logic [31:0] w_dout_ext;
    logic [31:0] w_din_ext;
    logic [31:0] w_dir_next;
    logic [31:0] w_dout_next;
    logic        w_unused;

    assign w_dir_ext  = 32'(r_dir);
    assign w_dout_ext = 32'(r_dout);
    assign w_din_ext  = 32'(r_sync2);
    assign w_unused   = ^{tl_i.a_param, tl_i.a_user};

    // Request decode, error classification, write merge and read mux
    always_comb begin
        w_off       = tl_i.a_address[7:0];
        w_in_window = (tl_i.a_address[31:8] == BASE_ADDR[31:8]);
        w_is_get    = (tl_i.a_opcode == GET);
        w_is_put    = (tl_i.a_opcode == PUT_FULL_DATA) || (tl_i.a_opcode == PUT_PARTIAL_DATA);
        w_mapped    = (w_off == c_off_data_in) || (w_off == c_off_dir) ||
                      (w_off == c_off_out_set) || (w_off == c_off_data_out) ||
                      (w_off == c_off_out_clr);
        w_err       = !w_in_window || (tl_i.a_address[1:0] != 2'b00) || !w_mapped ||
                      (tl_i.a_size != 2'd2) || !(w_is_get || w_is_put) ||
                      ((tl_i.a_opcode == PUT_FULL_DATA) && (tl_i.a_mask != 4'hF)) ||
                      (w_is_put && (w_off == c_off_data_in));
        w_accept    = tl_i.a_valid && (r_state == ST_IDLE);
        w_wr_en     = w_accept && w_is_put && !w_err;
        w_bmask     = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                       {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
        w_wdata     = tl_i.a_data & w_bmask;

        w_dir_next  = w_dir_ext;
        w_dout_next = w_dout_ext;
        if (w_wr_en) begin
            case (w_off)
                c_off_dir:      w_dir_next  = (w_dir_ext & ~w_bmask) | w_wdata;
                c_off_data_out: w_dout_next = (w_dout_ext & ~w_bmask) | w_wdata;
                c_off_out_set:  w_dout_next = w_dout_ext | w_wdata;
                c_off_out_clr:  w_dout_next = w_dout_ext & ~w_wdata;
                default:        ;
            endcase
        end

        // Write-only and erroring accesses return zero data
        w_rdata = 32'h0;
        if (w_is_get && !w_err) begin
            case (w_off)
                c_off_data_in:  w_rdata = w_din_ext;
                c_off_dir:      w_rdata = w_dir_ext;
                c_off_data_out: w_rdata = w_dout_ext;
                default:        w_rdata = 32'h0;
            endcase
        end
    end

    // Next-state: accept moves to RESP, D handshake returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (tl_i.a_valid) w_state_next = ST_RESP;
            ST_RESP: if (tl_i.d_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Two-stage synchronizer on the asynchronous pin inputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
        end
    end

    // Register file; writes land on the accepting edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dir  <= '0;
            r_dout <= '0;
        end else begin
            r_dir  <= w_dir_next[NUM_GPIO-1:0];
            r_dout <= w_dout_next[NUM_GPIO-1:0];
        end
    end

    // Response fields captured at acceptance and held until the D handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d_opcode <= ACCESS_ACK;
            r_d_size   <= 2'd0;
            r_d_source <= 8'd0;
            r_d_data   <= 32'h0;
            r_d_error  <= 1'b0;
        end else if (w_accept) begin
            r_d_opcode <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_data   <= w_rdata;
            r_d_error  <= w_err;
        end
    end

    // D channel and a_ready driven purely from flops
    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = (r_state == ST_RESP);
        tl_o.d_opcode = r_d_opcode;
        tl_o.d_param  = 3'd0;
        tl_o.d_size   = r_d_size;
        tl_o.d_source = r_d_source;
        tl_o.d_sink   = 1'b0;
        tl_o.d_data   = r_d_data;
        tl_o.d_user   = TL_D_USER_DEFAULT;
        tl_o.d_error  = r_d_error;
        tl_o.a_ready  = (r_state == ST_IDLE);
    end

    assign gpio_o    = r_dout;
    assign gpio_oe_o = r_dir;

endmodule
`default_nettype wire
